// File: rtl/extrinsic_interleaver.sv
// extrinsic_interleaver
//   Takes one frame of N a-posteriori LLRs, forms the extrinsic value
//   e[k] = LLR[k] - sys[k] - ext[k] (saturated to DATA_SIZE bits) one
//   element per cycle. It then presents the frame permuted by
//   pi(k) = 3k mod 7, or by its inverse, behind a valid/ready handshake.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   reset_n_i    asynchronous active-low reset
//   llr_valid_i  frame strobe (decoder finish)
//   llr_i        N signed LLRs, element 0 in the most significant slot
//   sys_i        N signed systematic soft bits, packed like llr_i
//   ext_i        N signed a-priori values, packed like llr_i
//   mode_i       0 = interleave (out[k] = e[pi(k)]), 1 = deinterleave (out[pi(k)] = e[k])
//   out_ready_i  consumer ready
//   out_valid_o  output frame valid
//   ext_o        output frame, packed like llr_i
//   hard_o       hard decisions of the captured LLRs, natural order
//                (present only when EXTRINSIC_HARD_DEC_EN is defined)
//   busy_o       FSM not idle
//   overrun_o    sticky: a frame strobe arrived while no frame could be accepted
//
// Build option: define EXTRINSIC_HARD_DEC_EN to add hard_o.
//
// state     | meaning
// S_IDLE    | waiting for llr_valid_i
// S_COMPUTE | one element per cycle, index 0..N-1
// S_OUTPUT  | out_valid_o high, waiting for out_ready_i

module extrinsic_interleaver #(
   parameter int DATA_SIZE = 10,
   parameter int SYS_SIZE  = 4,
   parameter int N         = 7
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   llr_valid_i,
   input  logic [N*DATA_SIZE-1:0] llr_i,
   input  logic [N*SYS_SIZE-1:0]  sys_i,
   input  logic [N*DATA_SIZE-1:0] ext_i,
   input  logic                   mode_i,
   input  logic                   out_ready_i,
   output logic                   out_valid_o,
   output logic [N*DATA_SIZE-1:0] ext_o,
`ifdef EXTRINSIC_HARD_DEC_EN
   output logic [N-1:0]           hard_o,
`endif
   output logic                   busy_o,
   output logic                   overrun_o
);

   localparam int IW = $clog2(N);
   // Working width: two extra bits hold the worst-case difference, never under 12.
   localparam int WW = (DATA_SIZE + 2 > 12) ? DATA_SIZE + 2 : 12;
   localparam logic signed [WW-1:0] SAT_MAX = WW'((1 <<< (DATA_SIZE - 1)) - 1);
   localparam logic signed [WW-1:0] SAT_MIN = WW'(-(1 <<< (DATA_SIZE - 1)));

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_OUTPUT  = 2'd2;

   logic [1:0]                  state;
   logic [IW-1:0]               idx;
   logic                        capture;

   logic signed [DATA_SIZE-1:0] llr_q [N];
   logic signed [SYS_SIZE-1:0]  sys_q [N];
   logic signed [DATA_SIZE-1:0] ext_q [N];
   logic                        mode_q;
   logic signed [DATA_SIZE-1:0] work  [N];

   logic signed [WW-1:0]        diff;
   logic signed [DATA_SIZE-1:0] e_cur;
   logic [IW-1:0]               dest;
   logic [N*DATA_SIZE-1:0]      out_pack;

   // Output slot for input element k. Interleave places e[k] at pi^-1(k) = 5k mod 7
   // because out[j] = e[pi(j)]; deinterleave places it at pi(k) = 3k mod 7.
   function automatic logic [IW-1:0] perm_dest(input logic [IW-1:0] k, input logic m);
      int d;
      if (m)
         d = (3 * int'(k)) % N;
      else
         d = (5 * int'(k)) % N;
      return IW'(d);
   endfunction

   // A new frame is accepted from IDLE, or from OUTPUT on the same edge the
   // current frame is handed off.
   assign capture = llr_valid_i &&
                    ((state == S_IDLE) || ((state == S_OUTPUT) && out_ready_i));

   assign busy_o      = (state != S_IDLE);
   assign out_valid_o = (state == S_OUTPUT);

   always_comb begin
      diff = WW'(llr_q[idx]) - WW'(sys_q[idx]) - WW'(ext_q[idx]);
      if (diff > SAT_MAX)
         e_cur = SAT_MAX[DATA_SIZE-1:0];
      else if (diff < SAT_MIN)
         e_cur = SAT_MIN[DATA_SIZE-1:0];
      else
         e_cur = diff[DATA_SIZE-1:0];
      dest = perm_dest(idx, mode_q);
   end

   // Final frame: the work buffer plus the element computed this cycle, so
   // ext_o loads on the last COMPUTE edge without an extra cycle.
   always_comb begin
      out_pack = '0;
      for (int k = 0; k < N; k++) begin
         if (IW'(k) == dest)
            out_pack[(N-1-k)*DATA_SIZE +: DATA_SIZE] = e_cur;
         else
            out_pack[(N-1-k)*DATA_SIZE +: DATA_SIZE] = work[k];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < N; k++) begin
            llr_q[k] <= '0;
            sys_q[k] <= '0;
            ext_q[k] <= '0;
         end
         mode_q <= 1'b0;
      end else if (capture) begin
         for (int k = 0; k < N; k++) begin
            llr_q[k] <= llr_i[(N-1-k)*DATA_SIZE +: DATA_SIZE];
            sys_q[k] <= sys_i[(N-1-k)*SYS_SIZE +: SYS_SIZE];
            ext_q[k] <= ext_i[(N-1-k)*DATA_SIZE +: DATA_SIZE];
         end
         mode_q <= mode_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= S_IDLE;
         idx       <= '0;
         ext_o     <= '0;
         overrun_o <= 1'b0;
         for (int k = 0; k < N; k++)
            work[k] <= '0;
`ifdef EXTRINSIC_HARD_DEC_EN
         hard_o    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (capture) begin
                  idx   <= '0;
                  state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (llr_valid_i)
                  overrun_o <= 1'b1;
               work[dest] <= e_cur;
               if (idx == IW'(N - 1)) begin
                  ext_o <= out_pack;
`ifdef EXTRINSIC_HARD_DEC_EN
                  for (int k = 0; k < N; k++)
                     hard_o[N-1-k] <= ~llr_q[k][DATA_SIZE-1];
`endif
                  idx   <= '0;
                  state <= S_OUTPUT;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_OUTPUT: begin
               if (out_ready_i) begin
                  idx   <= '0;
                  state <= capture ? S_COMPUTE : S_IDLE;
               end else if (llr_valid_i) begin
                  overrun_o <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_extrinsic_interleaver.sv
module tb_extrinsic_interleaver;

   localparam int DS = 10;
   localparam int SS = 4;
   localparam int NN = 7;
   localparam int W  = NN * DS;

   logic          clk_i       = 1'b0;
   logic          reset_n_i   = 1'b1;
   logic          llr_valid_i = 1'b0;
   logic [W-1:0]  llr_i       = '0;
   logic [NN*SS-1:0] sys_i    = '0;
   logic [W-1:0]  ext_i       = '0;
   logic          mode_i      = 1'b0;
   logic          out_ready_i = 1'b0;
   logic          out_valid_o;
   logic [W-1:0]  ext_o;
   logic          busy_o;
   logic          overrun_o;
`ifdef EXTRINSIC_HARD_DEC_EN
   logic [NN-1:0] hard_o;
`endif

   int errors = 0;
   int checks = 0;
   int llr_a [NN];
   int sys_a [NN];
   int ext_a [NN];

   extrinsic_interleaver dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .llr_valid_i (llr_valid_i),
      .llr_i       (llr_i),
      .sys_i       (sys_i),
      .ext_i       (ext_i),
      .mode_i      (mode_i),
      .out_ready_i (out_ready_i),
      .out_valid_o (out_valid_o),
      .ext_o       (ext_o),
`ifdef EXTRINSIC_HARD_DEC_EN
      .hard_o      (hard_o),
`endif
      .busy_o      (busy_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: saturated extrinsic per element, then permutation by its definition.
   function automatic logic [W-1:0] model_out(input logic m);
      int e [NN];
      int o [NN];
      int v;
      logic [W-1:0] r;
      for (int k = 0; k < NN; k++) begin
         v = llr_a[k] - sys_a[k] - ext_a[k];
         if (v > 511) v = 511;
         if (v < -512) v = -512;
         e[k] = v;
      end
      for (int k = 0; k < NN; k++) begin
         if (!m) o[k] = e[(3 * k) % 7];
         else    o[(3 * k) % 7] = e[k];
      end
      r = '0;
      for (int k = 0; k < NN; k++)
         r[(NN-1-k)*DS +: DS] = DS'(o[k]);
      return r;
   endfunction

   task automatic fill_const(input int l, input int s, input int x);
      for (int k = 0; k < NN; k++) begin
         llr_a[k] = l; sys_a[k] = s; ext_a[k] = x;
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < NN; k++) begin
         llr_a[k] = int'($urandom_range(0, 1023)) - 512;
         sys_a[k] = int'($urandom_range(0, 15)) - 8;
         ext_a[k] = int'($urandom_range(0, 1023)) - 512;
      end
   endtask

   task automatic scramble_inputs();
      llr_i = W'({$urandom(), $urandom(), $urandom()});
      ext_i = W'({$urandom(), $urandom(), $urandom()});
      sys_i = (NN*SS)'($urandom());
      mode_i = $urandom_range(0, 1) == 1;
   endtask

   // Called at a negedge; returns at the negedge after the capture edge.
   task automatic start_frame(input logic m);
      for (int k = 0; k < NN; k++) begin
         llr_i[(NN-1-k)*DS +: DS] = DS'(llr_a[k]);
         sys_i[(NN-1-k)*SS +: SS] = SS'(sys_a[k]);
         ext_i[(NN-1-k)*DS +: DS] = DS'(ext_a[k]);
      end
      mode_i = m;
      llr_valid_i = 1'b1;
      @(negedge clk_i);
      llr_valid_i = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid_o !== 1'b1 && n < 20) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic test_reset();
      reset_n_i = 1'b1;
      #2 reset_n_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
      checks++; if (ext_o !== '0) begin errors++; $display("FAIL reset_ext: got %h expected 0", ext_o); end
`ifdef EXTRINSIC_HARD_DEC_EN
      checks++; if (hard_o !== '0) begin errors++; $display("FAIL reset_hard: got %b expected 0", hard_o); end
`endif
      reset_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      int n;
      logic [W-1:0] exp_v;
      for (int k = 0; k < NN; k++) exp_v[(NN-1-k)*DS +: DS] = 10'd93;
      out_ready_i = 1'b1;
      fill_const(100, 2, 5);
      start_frame(1'b0);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_o); end
      scramble_inputs();
      wait_valid(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 7", n); end
      checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL basic_ext: got %h expected %h", ext_o, exp_v); end
      @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid_o); end
      checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL basic_hold: got %h expected %h", ext_o, exp_v); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy_o); end
   endtask

   task automatic test_saturation();
      int n;
      logic [W-1:0] exp_v;
      for (int k = 0; k < NN; k++) begin
         if (k % 2 == 0) begin llr_a[k] = 511;  sys_a[k] = -8; ext_a[k] = -512; end
         else            begin llr_a[k] = -512; sys_a[k] = 7;  ext_a[k] = 511;  end
      end
      exp_v = model_out(1'b0);
      out_ready_i = 1'b1;
      start_frame(1'b0);
      scramble_inputs();
      wait_valid(n);
      checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL sat_frame: got %h expected %h", ext_o, exp_v); end
      checks++; if (ext_o[69:60] !== 10'h1FF) begin errors++; $display("FAIL sat_pos: got %h expected 1ff", ext_o[69:60]); end
      checks++; if (ext_o[59:50] !== 10'h200) begin errors++; $display("FAIL sat_neg: got %h expected 200", ext_o[59:50]); end
      @(negedge clk_i);
   endtask

   task automatic test_permutation();
      int n;
      logic [W-1:0] exp0;
      logic [W-1:0] exp1;
      exp0 = {10'd0, 10'd30, 10'd60, 10'd20, 10'd50, 10'd10, 10'd40};
      exp1 = {10'd0, 10'd50, 10'd30, 10'd10, 10'd60, 10'd40, 10'd20};
      for (int k = 0; k < NN; k++) begin llr_a[k] = 10 * k; sys_a[k] = 0; ext_a[k] = 0; end
      out_ready_i = 1'b1;
      start_frame(1'b0);
      wait_valid(n);
      checks++; if (ext_o !== exp0) begin errors++; $display("FAIL perm_mode0: got %h expected %h", ext_o, exp0); end
      @(negedge clk_i);
      start_frame(1'b1);
      wait_valid(n);
      checks++; if (ext_o !== exp1) begin errors++; $display("FAIL perm_mode1: got %h expected %h", ext_o, exp1); end
      @(negedge clk_i);
   endtask

   task automatic test_random();
      int n;
      int d;
      logic m;
      logic [W-1:0] exp_v;
      for (int f = 0; f < 20; f++) begin
         fill_random();
         m = $urandom_range(0, 1) == 1;
         exp_v = model_out(m);
         d = int'($urandom_range(0, 3));
         out_ready_i = 1'b0;
         start_frame(m);
         scramble_inputs();
         wait_valid(n);
         checks++; if (n !== 7) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 7", f, n); end
         checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL rand_ext[%0d]: got %h expected %h", f, ext_o, exp_v); end
         repeat (d) @(negedge clk_i);
         checks++; if (out_valid_o !== 1'b1 || ext_o !== exp_v) begin errors++; $display("FAIL rand_hold[%0d]: valid %b ext %h expected 1 %h", f, out_valid_o, ext_o, exp_v); end
         out_ready_i = 1'b1;
         @(negedge clk_i);
         checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rand_drop[%0d]: got %b expected 0", f, out_valid_o); end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [W-1:0] exp_a;
      logic [W-1:0] exp_b;
      fill_random();
      exp_a = model_out(1'b1);
      out_ready_i = 1'b1;
      start_frame(1'b1);
      wait_valid(n);
      checks++; if (ext_o !== exp_a) begin errors++; $display("FAIL b2b_first: got %h expected %h", ext_o, exp_a); end
      fill_random();
      exp_b = model_out(1'b0);
      start_frame(1'b0);
      checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL b2b_handoff: valid %b busy %b expected 0 1", out_valid_o, busy_o); end
      checks++; if (ext_o !== exp_a) begin errors++; $display("FAIL b2b_hold: got %h expected %h", ext_o, exp_a); end
      scramble_inputs();
      wait_valid(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL b2b_latency: got %0d expected 7", n); end
      checks++; if (ext_o !== exp_b) begin errors++; $display("FAIL b2b_second: got %h expected %h", ext_o, exp_b); end
      @(negedge clk_i);
   endtask

   task automatic test_compute_ignore();
      int n;
      logic [W-1:0] exp_v;
      fill_random();
      exp_v = model_out(1'b0);
      out_ready_i = 1'b1;
      start_frame(1'b0);
      @(negedge clk_i);
      scramble_inputs();
      llr_valid_i = 1'b1;
      @(negedge clk_i);
      llr_valid_i = 1'b0;
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ignore_overrun: got %b expected 1", overrun_o); end
      wait_valid(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL ignore_latency: got %0d expected 5", n); end
      checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL ignore_ext: got %h expected %h", ext_o, exp_v); end
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ignore_idle: got %b expected 0", busy_o); end
   endtask

   task automatic test_reset_midframe();
      int n;
      int seen;
      logic [W-1:0] exp_v;
      fill_random();
      out_ready_i = 1'b1;
      start_frame(1'b1);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0 || ext_o !== '0) begin
         errors++; $display("FAIL midreset_outputs: valid %b busy %b overrun %b ext %h expected all 0", out_valid_o, busy_o, overrun_o, ext_o); end
      @(negedge clk_i);
      reset_n_i = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (out_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_partial: got %0d active cycles expected 0", seen); end
      fill_random();
      exp_v = model_out(1'b1);
      start_frame(1'b1);
      scramble_inputs();
      wait_valid(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL midreset_latency: got %0d expected 7", n); end
      checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL midreset_ext: got %h expected %h", ext_o, exp_v); end
      @(negedge clk_i);
   endtask

   task automatic test_backpressure();
      int n;
      logic [W-1:0] exp_v;
      fill_random();
      exp_v = model_out(1'b0);
      out_ready_i = 1'b0;
      start_frame(1'b0);
      wait_valid(n);
      checks++; if (ext_o !== exp_v) begin errors++; $display("FAIL bp_ext: got %h expected %h", ext_o, exp_v); end
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL bp_no_overrun: got %b expected 0", overrun_o); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         checks++; if (out_valid_o !== 1'b1 || ext_o !== exp_v) begin errors++; $display("FAIL bp_hold[%0d]: valid %b ext %h expected 1 %h", i, out_valid_o, ext_o, exp_v); end
         if (i == 1) begin scramble_inputs(); llr_valid_i = 1'b1; end
         if (i == 2) llr_valid_i = 1'b0;
      end
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun_o); end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL bp_release: valid %b busy %b expected 0 0", out_valid_o, busy_o); end
      checks++; if (ext_o !== exp_v || overrun_o !== 1'b1) begin errors++; $display("FAIL bp_after: ext %h overrun %b expected %h 1", ext_o, overrun_o, exp_v); end
   endtask

`ifdef EXTRINSIC_HARD_DEC_EN
   task automatic test_hard();
      int n;
      llr_a = '{-1, 0, 5, -300, 1, -512, 511};
      for (int k = 0; k < NN; k++) begin sys_a[k] = 0; ext_a[k] = 0; end
      out_ready_i = 1'b1;
      start_frame(1'b0);
      wait_valid(n);
      checks++; if (hard_o !== 7'b0110101) begin errors++; $display("FAIL hard_dec: got %b expected 0110101", hard_o); end
      @(negedge clk_i);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_permutation();
      test_random();
      test_back_to_back();
      test_compute_ignore();
      test_reset_midframe();
      test_backpressure();
`ifdef EXTRINSIC_HARD_DEC_EN
      test_hard();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/extrinsic_interleaver.md
EXTRINSIC_INTERLEAVER -- requirements
Module: extrinsic_interleaver

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 10, giving the LLR/extrinsic word width in bits.
REQ-002 SHALL have parameter SYS_SIZE, default 4, giving the systematic soft-bit width in bits.
REQ-003 SHALL have parameter N, default 7, giving the number of symbols per frame; the 7-entry permutation in REQ-013 is defined only for N=7.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port llr_valid_i  input  1  frame strobe, connected to the decoder's finish output.
REQ-007 SHALL have port llr_i  input  70  seven signed 10-bit a-posteriori LLRs; element 0 in [69:60], element 6 in [9:0].
REQ-008 SHALL have port sys_i  input  28  seven signed 4-bit systematic values; element 0 in [27:24].
REQ-009 SHALL have port ext_i  input  70  seven signed 10-bit a-priori values, packed like llr_i.
REQ-010 SHALL have ports mode_i (input, 1, 0=interleave, 1=deinterleave), out_ready_i (input, 1, consumer ready), out_valid_o (output, 1), ext_o (output, 70, packed like llr_i), busy_o (output, 1, state not IDLE) and overrun_o (output, 1, sticky dropped-frame flag).

Function
REQ-011 SHALL use an FSM with states IDLE, COMPUTE and OUTPUT.
REQ-012 SHALL, for element k, compute e[k] = LLR[k] - sext(sys[k]) - ext[k] in at least 12-bit signed arithmetic, then saturate to [-512, 511].
REQ-013 SHALL use pi(k) = (3k) mod 7 = {0,3,6,2,5,1,4}; mode 0 sets out[k] = e[pi(k)], mode 1 sets out[pi(k)] = e[k].
REQ-014 SHALL, in IDLE, register llr_i, sys_i, ext_i and mode_i on an edge with llr_valid_i=1, then enter COMPUTE with index 0.
REQ-015 SHALL, in COMPUTE, process exactly one element per cycle for k = 0..6 using the captured data only, then enter OUTPUT.
REQ-016 SHALL raise out_valid_o in the cycle after the 8th rising edge, counting the capture edge as the 1st.
REQ-017 SHALL, in OUTPUT, hold out_valid_o=1 and ext_o stable until an edge with out_ready_i=1, then drop out_valid_o on the next cycle.
REQ-018 SHALL, when llr_valid_i=1 and out_ready_i=1 fall on the same OUTPUT edge, complete the handshake, capture the new frame and enter COMPUTE.
REQ-019 SHALL ignore llr_valid_i in COMPUTE, or in OUTPUT with out_ready_i=0, set overrun_o=1 (cleared only by reset), and leave captured and output data unchanged.
REQ-020 SHALL hold ext_o at its last value once out_valid_o falls, until the next frame's output is loaded.

Reset
REQ-021 SHALL, on reset_n_i=0, immediately force state=IDLE, out_valid_o=0, busy_o=0, overrun_o=0, ext_o=0, and clear all capture registers and the element index.
REQ-022 SHALL abandon any frame in progress when reset asserts mid-frame, with no partial output; the first llr_valid_i after reset release is processed normally.

Configuration
REQ-023 SHALL, with macro EXTRINSIC_HARD_DEC_EN defined, add output port hard_o [6:0], where bit 6-k = 1 iff captured LLR[k] >= 0, in natural (unpermuted) order.
REQ-024 SHALL update hard_o on the same edge as ext_o and reset it to 0.
REQ-025 SHALL, without EXTRINSIC_HARD_DEC_EN, have neither the hard_o port nor its logic; all other behaviour is identical in both builds.

Verification
REQ-026 SHALL cover: all LLR=100, sys=2, ext=5, mode 0, out_ready=1 -> every ext_o element 93; out_valid_o high for exactly one cycle, after the 8th edge.
REQ-027 SHALL cover: LLR=511, sys=-8, ext=-512 -> 511; and LLR=-512, sys=7, ext=511 -> -512 (saturation).
REQ-028 SHALL cover: LLR[k]=10k, sys=ext=0 -> mode 0 gives {0,30,60,20,50,10,40}; mode 1 gives {0,50,30,10,60,40,20}.
REQ-029 SHALL cover: out_ready_i low for 5 cycles -> ext_o stable; llr_valid_i pulsed during the hold -> overrun_o=1, output unchanged; then out_ready_i=1 -> out_valid_o falls next cycle.
REQ-030 SHALL cover: reset pulsed on the 3rd COMPUTE cycle -> all outputs 0, state IDLE; next frame gives the correct result with REQ-016 latency.
REQ-031 SHALL cover: with EXTRINSIC_HARD_DEC_EN, LLR={-1,0,5,-300,1,-512,511} -> hard_o=7'b0110101.
